rst_sequencer: RTL

- Board-level reset controller between the clock wizard and the Tile.
- Synchronises and debounces the active-low reset button and monitors PLL lock.
- Accepts a soft-reset request from the core.
- Releases peripheral reset first, then core reset after a stagger, and records the cause of the last reset.

---
 rtl/rst_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Board reset sequencer: syncs and debounces the reset button, watches PLL lock,
// and releases peripheral reset before core reset, recording the last cause.
module rst_sequencer #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 64,
  parameter int STAGGER_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       periph_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [1:0] rst_cause
);

  localparam int MAX_HS =
    (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_P =
    (DEBOUNCE_CYCLES > MAX_HS) ? DEBOUNCE_CYCLES : MAX_HS;
  localparam int CW = $clog2(MAX_P);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STG_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_LOCK = 2'd2;
  localparam logic [1:0] CAUSE_SOFT = 2'd3;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    STAGGER,
    RUN
  } state_t;

  logic          lock_s1;
  logic          lock_s2;
  logic          btn_s1;
  logic          btn_s2;
  logic          db_level;
  logic [CW-1:0] db_cnt;
  logic          pressed;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    cause_nxt;
  logic          lock_lost;
  logic          soft_ok;
  logic          active;

  // Both raw inputs are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
      btn_s1  <= btn_rst_n;
      btn_s2  <= btn_s1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else if (btn_s2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= btn_s2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_ONE;
    end
  end

  assign pressed   = ~db_level;
  assign lock_lost = ~lock_s2;
  assign soft_ok   = soft_rst_req && (state == RUN);
  assign active    = (state != WAIT_LOCK);

  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt;
    cause_nxt = rst_cause;
    if (active && (lock_lost || pressed || soft_ok)) begin
      nxt     = WAIT_LOCK;
      cnt_nxt = '0;
      if (lock_lost) begin
        cause_nxt = CAUSE_LOCK;
      end else if (pressed) begin
        cause_nxt = CAUSE_BTN;
      end else begin
        cause_nxt = CAUSE_SOFT;
      end
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt_nxt = '0;
          if (lock_s2 && !pressed) begin
            nxt = HOLD;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            nxt     = STAGGER;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        STAGGER: begin
          if (cnt == STG_LAST) begin
            nxt     = RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        RUN: begin
          cnt_nxt = '0;
        end
        default: begin
          nxt     = WAIT_LOCK;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      periph_rst <= 1'b1;
      core_rst   <= 1'b1;
      ready      <= 1'b0;
      rst_cause  <= CAUSE_POR;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      periph_rst <= (nxt == WAIT_LOCK) || (nxt == HOLD);
      core_rst   <= (nxt != RUN);
      ready      <= (nxt == RUN);
      rst_cause  <= cause_nxt;
    end
  end

endmodule
